// File: rtl/mu0_run_ctrl.sv
// mu0_run_ctrl
//   Run/clock controller sitting directly in front of the mu0 core.
//   - Derives the core's slow clock from the fast system clock according to
//     the UART-selected clock mode (OFF / FAST / SLOW / MANUAL_OFF / MANUAL_ON).
//   - Turns the UART start toggle and the core's done flag into the run enable.
//   - Emits a one-cycle strobe (coreEdge) for each gated core rising edge and
//     counts those edges since the last run start.
//
// Optional feature macro: MU0_RUN_CTRL_WATCHDOG_EN
//   When defined, a run that reaches CYCLE_LIMIT core edges is stopped and
//   timeout is raised. When undefined, timeout is tied low and no limit logic
//   exists.
//
// Ports
//   clk         in   fast system clock
//   rstN        in   synchronous reset, active low
//   clkMode     in   [3:0] 0 OFF, 1 FAST, 2 SLOW, 3 MANUAL_OFF, 4 MANUAL_ON, 5..15 OFF
//   start       in   run request as a level toggle (any change = request)
//   done        in   core halted flag
//   slowClk     out  registered core clock before gating
//   enable      out  registered run enable
//   coreClk     out  slowClk & enable, drives mu0 .clk
//   coreEdge    out  strobe for each slowClk 0->1 while enabled
//   cycleCount  out  [31:0] core rising edges since last run start (saturating)
//   timeout     out  watchdog fired, sticky until the next run start
module mu0_run_ctrl #(
  parameter int unsigned SLOW_DIV    = 6318000,
  parameter int          DIV_W       = 32,
  parameter int unsigned CYCLE_LIMIT = 1000000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [3:0]  clkMode,
  input  logic        start,
  input  logic        done,
  output logic        slowClk,
  output logic        enable,
  output logic        coreClk,
  output logic        coreEdge,
  output logic [31:0] cycleCount,
  output logic        timeout
);

  localparam logic [3:0] MODE_FAST      = 4'd1;
  localparam logic [3:0] MODE_SLOW      = 4'd2;
  localparam logic [3:0] MODE_MANUAL_ON = 4'd4;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SLOW_DIV);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [3:0]       mode_q;
  logic [DIV_W-1:0] divider;
  logic             start_q;

  logic             mode_chg;
  logic             slow_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic             toggle;
  logic             wd_hit;
  logic             run_nxt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Clock generator next state. A mode change zeroes the divider so a new
  // SLOW period always starts with a full half-period.
  always_comb begin
    mode_chg = (clkMode != mode_q);
    slow_nxt = 1'b0;
    div_nxt  = divider;
    case (clkMode)
      MODE_FAST:      slow_nxt = ~slowClk;
      MODE_SLOW: begin
        slow_nxt = slowClk;
        if (!mode_chg) begin
          if (divider == DIV_MAX) begin
            div_nxt  = '0;
            slow_nxt = ~slowClk;
          end else begin
            div_nxt = divider + DIV_W'(1);
          end
        end
      end
      MODE_MANUAL_ON: slow_nxt = 1'b1;
      default:        slow_nxt = 1'b0;
    endcase
    if (mode_chg) div_nxt = '0;
  end

  assign toggle = (start != start_q);

`ifdef MU0_RUN_CTRL_WATCHDOG_EN
  localparam logic [31:0] LIMIT = 32'(CYCLE_LIMIT);

  assign wd_hit = (state == RUN) && (cycleCount >= LIMIT);

  // Sticky until a new run request; a request in the same cycle wins.
  always_ff @(posedge clk) begin
    if (!rstN)       timeout <= 1'b0;
    else if (toggle) timeout <= 1'b0;
    else if (wd_hit) timeout <= 1'b1;
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Enable value the FSM will hold after this edge; the edge strobe must use
  // it so no strobe is produced for an edge that lands as the run stops.
  assign run_nxt = toggle || ((state == RUN) && !wd_hit && !done);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      slowClk <= 1'b0;
      divider <= '0;
      mode_q  <= clkMode;
    end else begin
      slowClk <= slow_nxt;
      divider <= div_nxt;
      mode_q  <= clkMode;
    end
  end

  // Run FSM. A start present during reset is captured so it is not a request.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      start_q    <= start;
      coreEdge   <= 1'b0;
      cycleCount <= '0;
    end else begin
      start_q  <= start;
      coreEdge <= ~slowClk & slow_nxt & run_nxt;
      if (toggle)             cycleCount <= '0;
      else if (coreEdge)      cycleCount <= sat_inc(cycleCount);
      if (toggle)             state <= RUN;
      else if (wd_hit)        state <= IDLE;
      else if (state == RUN && done) state <= IDLE;
    end
  end

  assign enable  = (state == RUN);
  assign coreClk = slowClk & enable;

endmodule

// File: tb/tb_mu0_run_ctrl.sv
// Bench for mu0_run_ctrl: directed sequences followed by randomized traffic.
// A reference model predicts every cycle's outputs into a queue; a monitor
// pops and compares each cycle shortly after the clock edge.
module tb_mu0_run_ctrl;
  localparam int unsigned SDIV = 3;
  localparam int unsigned LIM  = 10;
`ifdef MU0_RUN_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [3:0]  clkMode = 4'd0;
  logic        start = 1'b0;
  logic        done = 1'b0;
  logic        slowClk, enable, coreClk, coreEdge, timeout;
  logic [31:0] cycleCount;

  always #5 clk = ~clk;

  mu0_run_ctrl #(.SLOW_DIV(SDIV), .DIV_W(8), .CYCLE_LIMIT(LIM)) dut (
    .clk(clk), .rstN(rstN), .clkMode(clkMode), .start(start), .done(done),
    .slowClk(slowClk), .enable(enable), .coreClk(coreClk), .coreEdge(coreEdge),
    .cycleCount(cycleCount), .timeout(timeout)
  );

  typedef struct packed {
    logic        slow;
    logic        en;
    logic        cclk;
    logic        edg;
    logic [31:0] cnt;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;

  // Reference model state, in terms of observable behaviour.
  bit          m_slow, m_run, m_edge, m_to, m_sq;
  int unsigned m_phase;      // clk cycles elapsed in the current slow half-period
  logic [3:0]  m_mode;
  longint unsigned m_cnt;    // core edges counted since run start

  task automatic model_step();
    bit old_slow, chg, tog, hit;
    exp_t e;
    if (!rstN) begin
      m_slow = 0; m_run = 0; m_edge = 0; m_to = 0; m_phase = 0;
      m_cnt = 0; m_sq = start; m_mode = clkMode;
    end else begin
      old_slow = m_slow;
      chg = (clkMode != m_mode);
      m_mode = clkMode;
      if (chg) m_phase = 0;
      if (clkMode == 4'd1) m_slow = !m_slow;
      else if (clkMode == 4'd2) begin
        if (!chg) begin
          if (m_phase == SDIV) begin m_phase = 0; m_slow = !m_slow; end
          else m_phase = m_phase + 1;
        end
      end
      else if (clkMode == 4'd4) m_slow = 1;
      else m_slow = 0;
      tog = (start != m_sq);
      m_sq = start;
      hit = WD && m_run && (m_cnt >= LIM);
      if (m_edge && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (tog) begin m_run = 1; m_cnt = 0; m_to = 0; end
      else if (hit) begin m_run = 0; m_to = 1; end
      else if (m_run && done) m_run = 0;
      m_edge = !old_slow && m_slow && m_run;
    end
    e.slow = m_slow; e.en = m_run; e.cclk = m_slow & m_run; e.edg = m_edge;
    e.cnt = m_cnt[31:0]; e.to = m_to;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [3:0] m, input logic s, input logic d);
    @(negedge clk);
    rstN = r; clkMode = m; start = s; done = d;
    @(posedge clk);
    model_step();
  endtask

  logic s_lvl = 1'b0;

  task automatic run(input int n, input logic [3:0] m, input logic d);
    for (int i = 0; i < n; i++) drive(1'b1, m, s_lvl, d);
  endtask

  task automatic tog(input logic [3:0] m, input logic d);
    s_lvl = ~s_lvl;
    drive(1'b1, m, s_lvl, d);
  endtask

  // Monitor: compares each predicted cycle against the DUT.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got.slow = slowClk; got.en = enable; got.cclk = coreClk; got.edg = coreEdge;
        got.cnt = cycleCount; got.to = timeout;
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL cyc%0d {slow,en,cclk,edge,cnt,to} got=%b,%b,%b,%b,%0d,%b exp=%b,%b,%b,%b,%0d,%b",
                   cyc_no, got.slow, got.en, got.cclk, got.edg, got.cnt, got.to,
                   e.slow, e.en, e.cclk, e.edg, e.cnt, e.to);
        end
      end
    end
  end

  initial begin
    int pick;
    logic [3:0] rmode;
    // Reset with start high: no run afterwards.
    s_lvl = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 4'd0, 1'b1, 1'b0);
    run(3, 4'd1, 1'b0);
    // FAST run, then done, then done+toggle together.
    tog(4'd1, 1'b0);
    run(12, 4'd1, 1'b0);
    run(1, 4'd1, 1'b1);
    run(4, 4'd1, 1'b0);
    tog(4'd1, 1'b1);
    run(4, 4'd1, 1'b0);
    // SLOW, FAST, SLOW again (divider restart).
    run(14, 4'd2, 1'b0);
    run(3, 4'd1, 1'b0);
    run(12, 4'd2, 1'b0);
    // Manual modes and an undefined mode value.
    run(3, 4'd3, 1'b0);
    run(3, 4'd4, 1'b0);
    run(2, 4'd3, 1'b0);
    run(3, 4'd7, 1'b0);
    // Long FAST run (watchdog limit when enabled), then a new request.
    tog(4'd1, 1'b0);
    run(30, 4'd1, 1'b0);
    tog(4'd1, 1'b0);
    run(5, 4'd1, 1'b0);
    // Two consecutive toggles, then reset mid-run in SLOW.
    run(1, 4'd1, 1'b1);
    tog(4'd1, 1'b0);
    tog(4'd1, 1'b0);
    run(4, 4'd2, 1'b0);
    drive(1'b0, 4'd2, s_lvl, 1'b0);
    run(8, 4'd2, 1'b0);
    // Randomized traffic.
    rmode = 4'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        pick = $urandom_range(0, 9);
        if (pick < 4) rmode = 4'd1;
        else if (pick < 7) rmode = 4'd2;
        else if (pick == 7) rmode = 4'd3;
        else if (pick == 8) rmode = 4'd4;
        else rmode = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 24) == 0) s_lvl = ~s_lvl;
      drive(($urandom_range(0, 199) != 0), rmode, s_lvl, ($urandom_range(0, 19) == 0));
    end
    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain leftover=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
